// File: rtl/timer_count_ctrl.sv
// ---------------------------------------------------------------------------
// timer_count_ctrl
//   Sequencing controller for one timer channel. Takes the live configuration
//   from the timer register block, shadows max count and prescale at LOAD,
//   and runs the IDLE/LOAD/RUN/DONE counter FSM.
//
//   Ports
//     clk        in   1      clock, rising edge
//     rst        in   1      asynchronous reset, active-high
//     ctrl_en    in   1      channel enable level; low forces IDLE
//     ctrl_mode  in   1      0 = periodic (auto-reload), 1 = one-shot
//     start      in   1      single-cycle start strobe
//     stop       in   1      single-cycle stop strobe
//     irq_clr    in   1      single-cycle clear of sticky irq
//     cnt_max    in   CNT_W  terminal count value (live)
//     prescale   in   PS_W   one count tick every prescale+1 clocks
//     cnt_value  out  CNT_W  current count
//     running    out  1      high in LOAD or RUN
//     done       out  1      high in DONE
//     expired    out  1      one-cycle pulse per terminal count
//     irq        out  1      sticky interrupt
//
//   state | meaning
//   IDLE  | channel stopped, count held at zero
//   LOAD  | one cycle, shadows max count and prescale, clears counters
//   RUN   | prescaler and counter advancing
//   DONE  | one-shot finished, count held at max
// ---------------------------------------------------------------------------
module timer_count_ctrl #(
    parameter int CNT_W = 32,
    parameter int PS_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_en,
    input  logic             ctrl_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_clr,
    input  logic [CNT_W-1:0] cnt_max,
    input  logic [PS_W-1:0]  prescale,
    output logic [CNT_W-1:0] cnt_value,
    output logic             running,
    output logic             done,
    output logic             expired,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [PS_W-1:0]  ps_cnt;
    logic [PS_W-1:0]  ps_nxt;
    logic [CNT_W-1:0] max_sh;
    logic [CNT_W-1:0] max_nxt;
    logic [PS_W-1:0]  ps_sh;
    logic [PS_W-1:0]  ps_sh_nxt;
    logic             term;
    logic             term_q;
    logic             tick;

    assign tick = (ps_cnt == ps_sh);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_value;
        ps_nxt    = ps_cnt;
        max_nxt   = max_sh;
        ps_sh_nxt = ps_sh;
        term      = 1'b0;

        // stop and enable loss override everything, including a start in the
        // same cycle and a terminal tick in the same cycle
        if (stop || (!ctrl_en && (state != S_IDLE))) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            ps_nxt    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_nxt = '0;
                    ps_nxt  = '0;
                    if (start && ctrl_en) begin
                        state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    max_nxt   = cnt_max;
                    ps_sh_nxt = prescale;
                    cnt_nxt   = '0;
                    ps_nxt    = '0;
                    state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (start) begin
                        // restart: no expiry even if this was a terminal tick
                        state_nxt = S_LOAD;
                        cnt_nxt   = '0;
                        ps_nxt    = '0;
                    end else if (tick) begin
                        ps_nxt = '0;
                        if (cnt_value == max_sh) begin
                            term = 1'b1;
                            if (ctrl_mode) begin
                                state_nxt = S_DONE;
                                cnt_nxt   = max_sh;
                            end else begin
                                cnt_nxt = '0;
                            end
                        end else begin
                            cnt_nxt = cnt_value + CNT_W'(1);
                        end
                    end else begin
                        ps_nxt = ps_cnt + PS_W'(1);
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_nxt = S_LOAD;
                        cnt_nxt   = '0;
                        ps_nxt    = '0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    ps_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt_value <= '0;
            ps_cnt    <= '0;
            max_sh    <= '0;
            ps_sh     <= '0;
        end else begin
            state     <= state_nxt;
            cnt_value <= cnt_nxt;
            ps_cnt    <= ps_nxt;
            max_sh    <= max_nxt;
            ps_sh     <= ps_sh_nxt;
        end
    end

    // The terminal tick is captured first and presented as expired/irq one
    // cycle later; a pending pulse completes even if the FSM leaves RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_q  <= 1'b0;
            expired <= 1'b0;
            irq     <= 1'b0;
        end else begin
            term_q  <= term;
            expired <= term_q;
            if (term_q) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

    assign running = (state == S_LOAD) || (state == S_RUN);
    assign done    = (state == S_DONE);

endmodule
